// File: rtl/key_schedule_ctrl_if.sv
// G-function handshake bundle between the key schedule controller and the
// shared G block (RotWord, SubWord, Rcon).
//   g_enable  ctrl -> G   one-cycle start pulse
//   g_word    ctrl -> G   input word, held from g_enable until g_done
//   g_round   ctrl -> G   round number 1..10, held from g_enable until g_done
//   g_result  G -> ctrl   G output, valid while g_done = 1
//   g_done    G -> ctrl   completion pulse
interface key_schedule_ctrl_if;
  logic        g_enable;
  logic [31:0] g_word;
  logic [3:0]  g_round;
  logic [31:0] g_result;
  logic        g_done;

  modport master (output g_enable, g_word, g_round, input g_result, g_done);
  modport slave  (input g_enable, g_word, g_round, output g_result, g_done);
endinterface

// File: rtl/key_schedule_ctrl.sv
// AES-128 key expansion sequencer. Latches the cipher key, calls the shared
// G block once per round, XOR-chains the G result into the four words of each
// round key and stores round keys 0..NUM_ROUNDS for random-access readout.
//   clk, n_rst   clock (rising edge), asynchronous active-low reset
//   start        expand key_in; sampled only in IDLE
//   key_in       cipher key, w0 = key_in[127:96]
//   busy         high in every state except IDLE
//   done         one-cycle pulse when all round keys are stored
//   key_ready    all round keys valid
//   err          sticky G timeout flag
//   g_if         G handshake (master side)
//   rk_addr      round-key read index
//   rk_data      combinational round-key read, 0 for indices above NUM_ROUNDS
module key_schedule_ctrl #(
  parameter int NUM_ROUNDS = 10,
  parameter int G_TIMEOUT  = 31
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic                       start,
  input  logic [127:0]               key_in,
  output logic                       busy,
  output logic                       done,
  output logic                       key_ready,
  output logic                       err,
  key_schedule_ctrl_if.master        g_if,
  input  logic [3:0]                 rk_addr,
  output logic [127:0]               rk_data
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_GREQ  = 3'd1;
  localparam logic [2:0] S_GWAIT = 3'd2;
  localparam logic [2:0] S_MIX   = 3'd3;
  localparam logic [2:0] S_FIN   = 3'd4;

  localparam int TW = $clog2(G_TIMEOUT + 1);

  logic [2:0]    r_state;
  logic [3:0]    r_round;
  logic [TW-1:0] r_tcnt;
  logic [31:0]   r_gtmp;
  logic          r_key_ready;
  logic          r_err;
  logic [127:0]  r_rk [NUM_ROUNDS+1];

  logic [3:0]    w_pidx;
  logic [127:0]  w_prev;
  logic [31:0]   w_n0, w_n1, w_n2, w_n3;
  logic [TW-1:0] w_tcnt_nxt;
  logic          w_g_hold;

  // Previous round key; round is 1..NUM_ROUNDS whenever this is consumed,
  // the round==0 guard only keeps the index in range while idle.
  assign w_pidx = (r_round == 4'd0) ? 4'd0 : r_round - 4'd1;
  assign w_prev = r_rk[w_pidx];

  assign w_n0 = w_prev[127:96] ^ r_gtmp;
  assign w_n1 = w_prev[95:64]  ^ w_n0;
  assign w_n2 = w_prev[63:32]  ^ w_n1;
  assign w_n3 = w_prev[31:0]   ^ w_n2;

  assign w_tcnt_nxt = r_tcnt + 1'b1;

  // G samples its inputs late, so word/round are driven straight from
  // stored state, which cannot change between G_REQ and the g_done cycle.
  assign w_g_hold      = (r_state == S_GREQ) || (r_state == S_GWAIT);
  assign g_if.g_enable = (r_state == S_GREQ);
  assign g_if.g_word   = w_g_hold ? w_prev[31:0] : 32'd0;
  assign g_if.g_round  = w_g_hold ? r_round : 4'd0;

  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_FIN);
  assign key_ready = r_key_ready;
  assign err       = r_err;

  always_comb begin
    rk_data = '0;
    if (rk_addr <= 4'(NUM_ROUNDS)) rk_data = r_rk[rk_addr];
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state     <= S_IDLE;
      r_round     <= '0;
      r_tcnt      <= '0;
      r_gtmp      <= '0;
      r_key_ready <= 1'b0;
      r_err       <= 1'b0;
      for (int i = 0; i <= NUM_ROUNDS; i++) r_rk[i] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_rk[0]     <= key_in;
            r_round     <= 4'd1;
            r_key_ready <= 1'b0;
            r_err       <= 1'b0;
            r_state     <= S_GREQ;
          end
        end
        S_GREQ: begin
          r_tcnt  <= '0;
          r_state <= S_GWAIT;
        end
        S_GWAIT: begin
          // g_done wins over a timeout expiring in the same cycle.
          if (g_if.g_done) begin
            r_gtmp  <= g_if.g_result;
            r_state <= S_MIX;
          end else if (w_tcnt_nxt == TW'(G_TIMEOUT)) begin
            r_err   <= 1'b1;
            r_round <= '0;
            r_state <= S_IDLE;
          end else begin
            r_tcnt <= w_tcnt_nxt;
          end
        end
        S_MIX: begin
          r_rk[r_round] <= {w_n0, w_n1, w_n2, w_n3};
          if (r_round == 4'(NUM_ROUNDS)) begin
            r_state <= S_FIN;
          end else begin
            r_round <= r_round + 4'd1;
            r_state <= S_GREQ;
          end
        end
        S_FIN: begin
          r_key_ready <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_key_schedule_ctrl.sv
module tb_key_schedule_ctrl;
  localparam int NR = 10;
  localparam int GT = 31;
  localparam logic [127:0] KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  logic         clk = 1'b0;
  logic         n_rst = 1'b0;
  logic         start = 1'b0;
  logic [127:0] key_in = '0;
  logic         busy, done, key_ready, err;
  logic [3:0]   rk_addr = '0;
  logic [127:0] rk_data;

  key_schedule_ctrl_if gif ();

  key_schedule_ctrl #(.NUM_ROUNDS(NR), .G_TIMEOUT(GT)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .key_in(key_in),
    .busy(busy), .done(done), .key_ready(key_ready), .err(err),
    .g_if(gif), .rk_addr(rk_addr), .rk_data(rk_data)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // AES S-box, byte b at bits [b*8 +: 8]
  logic [0:2047] sb_tab = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return sb_tab[int'(b)*8 +: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1: return 8'h01;  4'd2: return 8'h02;  4'd3: return 8'h04;
      4'd4: return 8'h08;  4'd5: return 8'h10;  4'd6: return 8'h20;
      4'd7: return 8'h40;  4'd8: return 8'h80;  4'd9: return 8'h1b;
      4'd10: return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] g_real(input logic [31:0] w, input logic [3:0] r);
    return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])} ^ {rcon(r), 24'h0};
  endfunction

  // G model: mode 0 = real G, latency 12; 1 = never answers; 2 = zero-before-Rcon stub,
  // random latency 2..20. Inputs are sampled on the cycle before g_done rises.
  int g_mode = 0;
  int pend;
  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pend <= 0;
      gif.g_done <= 1'b0;
      gif.g_result <= '0;
    end else begin
      gif.g_done <= 1'b0;
      if (gif.g_enable) begin
        if (g_mode != 1) pend <= (g_mode == 0) ? 11 : int'($urandom_range(19, 1));
      end else if (pend > 0) begin
        pend <= pend - 1;
        if (pend == 1) begin
          gif.g_done <= 1'b1;
          gif.g_result <= (g_mode == 0) ? g_real(gif.g_word, gif.g_round) : {rcon(gif.g_round), 24'h0};
        end
      end
    end
  end

  // Results of the last run_exp call; cycle c = c-th cycle after the start edge.
  int done_cyc, done_cnt, end_cyc, en_cnt, hold_bad;
  logic [3:0]  en_round [16];
  logic [31:0] en_word  [16];

  task automatic run_exp(input logic [127:0] key, input int restart_at);
    logic [31:0] hw;
    logic [3:0]  hr;
    logic        holding;
    done_cyc = -1; done_cnt = 0; end_cyc = -1; en_cnt = 0; hold_bad = 0; holding = 1'b0;
    hw = '0; hr = '0;
    @(negedge clk); key_in = key; start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int c = 1; c <= 400; c++) begin
      if (c > 1) @(negedge clk);
      if (c == restart_at) begin start = 1'b1; key_in = ~key; end
      else if (c == restart_at + 1) begin start = 1'b0; key_in = key; end
      if (gif.g_enable) begin
        if (en_cnt < 16) begin en_round[en_cnt] = gif.g_round; en_word[en_cnt] = gif.g_word; end
        en_cnt++; hw = gif.g_word; hr = gif.g_round; holding = 1'b1;
      end else if (holding && (gif.g_word !== hw || gif.g_round !== hr)) hold_bad++;
      if (gif.g_done) holding = 1'b0;
      if (done) begin done_cnt++; if (done_cyc < 0) done_cyc = c; end
      if (!busy) begin end_cyc = c; break; end
    end
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if ({busy, done, key_ready, err} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b want 0000", {busy, done, key_ready, err}); end
    checks++; if ({gif.g_enable, gif.g_word, gif.g_round} !== 37'd0) begin errors++; $display("FAIL reset_g: got %h want 0", {gif.g_enable, gif.g_word, gif.g_round}); end
    rk_addr = 4'd10; #1;
    checks++; if (rk_data !== 128'd0) begin errors++; $display("FAIL reset_rk10: got %h want 0", rk_data); end
    @(negedge clk); n_rst = 1'b1;
  endtask

  task automatic test_fips();
    g_mode = 0;
    run_exp(KEY, -1);
    checks++; if (done_cyc != 141) begin errors++; $display("FAIL fips_done_cycle: got %0d want 141", done_cyc); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL fips_done_width: got %0d want 1", done_cnt); end
    checks++; if (end_cyc != 142) begin errors++; $display("FAIL fips_busy_end: got %0d want 142", end_cyc); end
    checks++; if (key_ready !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL fips_flags: got kr=%b err=%b want kr=1 err=0", key_ready, err); end
    rk_addr = 4'd0; #1;
    checks++; if (rk_data !== KEY) begin errors++; $display("FAIL fips_rk0: got %h want %h", rk_data, KEY); end
    rk_addr = 4'd1; #1;
    checks++; if (rk_data !== RK1) begin errors++; $display("FAIL fips_rk1: got %h want %h", rk_data, RK1); end
    rk_addr = 4'd10; #1;
    checks++; if (rk_data !== RK10) begin errors++; $display("FAIL fips_rk10: got %h want %h", rk_data, RK10); end
  endtask

  task automatic test_g_handshake();
    int bad_rounds;
    g_mode = 0;
    run_exp(KEY, -1);
    checks++; if (en_cnt != 10) begin errors++; $display("FAIL hs_enable_count: got %0d want 10", en_cnt); end
    checks++; if (en_word[0] !== 32'h09cf4f3c || en_round[0] !== 4'd1) begin errors++; $display("FAIL hs_round1: got word=%h round=%0d want 09cf4f3c 1", en_word[0], en_round[0]); end
    checks++; if (en_word[1] !== 32'h2a6c7605) begin errors++; $display("FAIL hs_round2_word: got %h want 2a6c7605", en_word[1]); end
    checks++; if (hold_bad != 0) begin errors++; $display("FAIL hs_hold: got %0d changes want 0", hold_bad); end
    bad_rounds = 0;
    for (int i = 1; i < 10; i++) if (en_round[i] !== 4'(i + 1)) bad_rounds++;
    checks++; if (bad_rounds != 0) begin errors++; $display("FAIL hs_round_seq: got %0d wrong rounds want 0", bad_rounds); end
  endtask

  task automatic test_start_while_busy();
    g_mode = 0;
    run_exp(KEY, 50);
    checks++; if (done_cyc != 141 || done_cnt != 1) begin errors++; $display("FAIL busy_start_done: got cyc=%0d cnt=%0d want 141 1", done_cyc, done_cnt); end
    rk_addr = 4'd0; #1;
    checks++; if (rk_data !== KEY) begin errors++; $display("FAIL busy_start_rk0: got %h want %h", rk_data, KEY); end
    rk_addr = 4'd1; #1;
    checks++; if (rk_data !== RK1) begin errors++; $display("FAIL busy_start_rk1: got %h want %h", rk_data, RK1); end
    rk_addr = 4'd10; #1;
    checks++; if (rk_data !== RK10) begin errors++; $display("FAIL busy_start_rk10: got %h want %h", rk_data, RK10); end
  endtask

  task automatic test_timeout();
    g_mode = 1;
    run_exp(KEY, -1);
    checks++; if (end_cyc != 1 + 1 + GT) begin errors++; $display("FAIL to_busy_end: got %0d want %0d", end_cyc, 1 + 1 + GT); end
    checks++; if (err !== 1'b1 || key_ready !== 1'b0) begin errors++; $display("FAIL to_flags: got err=%b kr=%b want err=1 kr=0", err, key_ready); end
    checks++; if (done_cnt != 0) begin errors++; $display("FAIL to_no_done: got %0d pulses want 0", done_cnt); end
    g_mode = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    checks++; if (err !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL to_restart_clear: got err=%b busy=%b want 0 1", err, busy); end
    repeat (150) @(negedge clk);
    checks++; if (key_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL to_recover: got kr=%b busy=%b want 1 0", key_ready, busy); end
  endtask

  task automatic test_reset_mid();
    int nz;
    g_mode = 0;
    @(negedge clk); key_in = KEY; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (59) @(negedge clk);  // cycle 60: round 5 in G_WAIT
    checks++; if (busy !== 1'b1 || gif.g_round !== 4'd5) begin errors++; $display("FAIL rmid_pre: got busy=%b round=%0d want 1 5", busy, gif.g_round); end
    n_rst = 1'b0;
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    checks++; if ({busy, key_ready, err, done} !== 4'b0) begin errors++; $display("FAIL rmid_flags: got %b want 0000", {busy, key_ready, err, done}); end
    nz = 0;
    for (int a = 0; a < 16; a++) begin rk_addr = 4'(a); #1; if (rk_data !== 128'd0) nz++; end
    checks++; if (nz != 0) begin errors++; $display("FAIL rmid_rk_clear: got %0d nonzero entries want 0", nz); end
    run_exp(KEY, -1);
    checks++; if (done_cyc != 141) begin errors++; $display("FAIL rmid_done_cycle: got %0d want 141", done_cyc); end
    rk_addr = 4'd1; #1;
    checks++; if (rk_data !== RK1) begin errors++; $display("FAIL rmid_rk1: got %h want %h", rk_data, RK1); end
    rk_addr = 4'd10; #1;
    checks++; if (rk_data !== RK10) begin errors++; $display("FAIL rmid_rk10: got %h want %h", rk_data, RK10); end
  endtask

  task automatic test_random_stub();
    logic [127:0] k, exp_rk [NR+1];
    logic [31:0]  g, n0, n1, n2, n3;
    k = 128'h000102030405060708090a0b0c0d0e0f;
    exp_rk[0] = k;
    for (int r = 1; r <= NR; r++) begin
      g  = {rcon(4'(r)), 24'h0};
      n0 = exp_rk[r-1][127:96] ^ g;
      n1 = exp_rk[r-1][95:64] ^ n0;
      n2 = exp_rk[r-1][63:32] ^ n1;
      n3 = exp_rk[r-1][31:0] ^ n2;
      exp_rk[r] = {n0, n1, n2, n3};
    end
    g_mode = 2;
    run_exp(k, -1);
    checks++; if (done_cnt != 1 || key_ready !== 1'b1 || end_cyc < 0) begin errors++; $display("FAIL rnd_done: got cnt=%0d kr=%b end=%0d want 1 1 >=0", done_cnt, key_ready, end_cyc); end
    checks++; if (hold_bad != 0) begin errors++; $display("FAIL rnd_hold: got %0d changes want 0", hold_bad); end
    for (int r = 0; r <= NR; r++) begin
      rk_addr = 4'(r); #1;
      checks++; if (rk_data !== exp_rk[r]) begin errors++; $display("FAIL rnd_rk%0d: got %h want %h", r, rk_data, exp_rk[r]); end
    end
    rk_addr = 4'd15; #1;
    checks++; if (rk_data !== 128'd0) begin errors++; $display("FAIL rnd_addr15: got %h want 0", rk_data); end
    g_mode = 0;
  endtask

  initial begin
    test_reset();
    test_fips();
    test_g_handshake();
    test_start_while_busy();
    test_timeout();
    test_reset_mid();
    test_random_stub();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
